decode_stage_p: RTL and testbench
=================================

DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 Parameters (name, default, meaning): XLEN, 32, datapath width; NREG, 32, architectural registers, 16 or 32; CTRL_W, 9, width of decoded control bundle.
REQ-002 Reset rst, asynchronous, active-low; clock clk.
REQ-003 Ports (name direction width meaning):
- clk in 1 clock
- rst in 1 async active-low reset
- instr_d in 32 instruction in decode
- valid_d in 1 instr_d holds a real instruction
- ctrl_d in CTRL_W decoded control bundle
- imm_d in XLEN extended immediate
- pc_d, pcplus4_d in XLEN PC and PC+4
- stall_d in 1 hold ID/EX contents
- flush_e in 1 insert bubble into EX
- regwrite_w in 1 writeback enable
- rd_w in 5 writeback address
- result_w in XLEN writeback data
- valid_e out 1 EX slot valid
- ctrl_e out CTRL_W registered control
- rd1_e, rd2_e out XLEN registered operands
- imm_e, pc_e, pcplus4_e out XLEN registered copies
- rs1_e, rs2_e, rd_e out 5 registered instr_d[19:15], [24:20], [11:7]

Function
REQ-004 Internal register file SHALL hold NREG entries of XLEN bits; entry 0 SHALL always read zero and ignore writes.
REQ-005 Register-file write SHALL occur on posedge clk when regwrite_w=1, rd_w!=0 and rd_w<NREG.
REQ-006 Reads of rs1/rs2 SHALL be combinational; address >= NREG SHALL read zero.
REQ-007 ID/EX register SHALL update on every posedge clk unless held or flushed; latency decode->EX outputs exactly 1 cycle.
REQ-008 flush_e=1 SHALL load a bubble: valid_e=0, ctrl_e=0, all other EX outputs 0; flush SHALL take priority over stall_d.
REQ-009 stall_d=1 with flush_e=0 SHALL hold all EX outputs unchanged; register-file writes SHALL still occur during stall.
REQ-010 valid_d=0 (no flush, no stall) SHALL load valid_e=0 and ctrl_e=0; data fields SHALL load normally.
REQ-011 ctrl_e SHALL never be nonzero while valid_e=0.
REQ-012 During a stall, a writeback to a register named by rs1_e/rs2_e SHALL NOT alter rd1_e/rd2_e (EX forwarding is external).
REQ-013 Widths: all data paths XLEN bits, no truncation or extension inside the block.

Reset
REQ-014 rst=0 SHALL asynchronously clear all EX outputs (valid_e=0, ctrl_e=0, data 0, indices 0) and all register-file entries to 0.
REQ-015 Reset asserted mid-stall or mid-write SHALL dominate; the first posedge after release SHALL behave as REQ-007.

Configuration
REQ-016 Macro DECODE_STAGE_BYPASS_EN defined: when regwrite_w=1, rd_w!=0, rd_w<NREG and rd_w equals rs1/rs2 of instr_d, the corresponding operand SHALL be result_w (same-cycle write-through).
REQ-017 DECODE_STAGE_BYPASS_EN undefined: operands SHALL be the pre-write register contents; the hazard is resolved externally by a 1-cycle stall.

Verification
REQ-018 Reset, then write x5=0x1234 (regwrite_w=1, rd_w=5); next cycle instr_d rs1=5, valid_d=1 -> one cycle later rd1_e=0x1234, valid_e=1, rs1_e=5.
REQ-019 Write rd_w=0 result_w=0xFFFF_FFFF, then read x0 -> rd1_e=0; NREG=16, read rs1=20 -> rd1_e=0.
REQ-020 Same cycle: regwrite_w=1, rd_w=7, result_w=0xAA, instr_d rs2=7 (x7 previously 0x11) -> rd2_e=0xAA with DECODE_STAGE_BYPASS_EN, 0x11 without.
REQ-021 Load ctrl_d=0x1FF, valid_d=1; assert stall_d 3 cycles with changing instr_d -> ctrl_e=0x1FF and all EX outputs constant for 3 cycles.
REQ-022 stall_d=1 and flush_e=1 together -> next cycle valid_e=0, ctrl_e=0, rd1_e=0, pc_e=0.
REQ-023 Assert rst=0 between clock edges while valid_e=1 -> outputs clear immediately; reading x5 after release returns 0.

Source files
------------

// File: rtl/decode_stage_p.sv
// Decode stage: register file read plus ID/EX pipeline register with stall/flush.
// Optional same-cycle writeback bypass into operand reads: define DECODE_STAGE_BYPASS_EN.
module decode_stage_p #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int CTRL_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_d,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pcplus4_d,
    input  logic              stall_d,
    input  logic              flush_e,
    input  logic              regwrite_w,
    input  logic [4:0]        rd_w,
    input  logic [XLEN-1:0]   result_w,
    output logic              valid_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pcplus4_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic [4:0]        rd_e
);

    localparam int         AW     = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    logic [XLEN-1:0] rf_q [NREG];

    logic [4:0]      rs1_a, rs2_a, rd_a;
    logic            rf_we;
    logic [XLEN-1:0] rd1_rf, rd2_rf;
    logic            unused_instr;

    assign rs1_a        = instr_d[19:15];
    assign rs2_a        = instr_d[24:20];
    assign rd_a         = instr_d[11:7];
    assign unused_instr = ^{instr_d[31:25], instr_d[14:12], instr_d[6:0]};

    assign rf_we = regwrite_w && (rd_w != 5'd0) && ({1'b0, rd_w} < NREG_L);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rd_w[AW-1:0]] <= result_w;
        end
    end

    // x0 and out-of-range addresses read as zero
    always_comb begin
        rd1_rf = '0;
        rd2_rf = '0;
        if (rs1_a != 5'd0 && {1'b0, rs1_a} < NREG_L) rd1_rf = rf_q[rs1_a[AW-1:0]];
        if (rs2_a != 5'd0 && {1'b0, rs2_a} < NREG_L) rd2_rf = rf_q[rs2_a[AW-1:0]];
`ifdef DECODE_STAGE_BYPASS_EN
        if (rf_we && rd_w == rs1_a) rd1_rf = result_w;
        if (rf_we && rd_w == rs2_a) rd2_rf = result_w;
`endif
    end

    logic              valid_q, valid_d_n;
    logic [CTRL_W-1:0] ctrl_q, ctrl_dn;
    logic [XLEN-1:0]   rd1_q, rd1_dn, rd2_q, rd2_dn;
    logic [XLEN-1:0]   imm_q, imm_dn, pc_q, pc_dn, pc4_q, pc4_dn;
    logic [4:0]        rs1_q, rs1_dn, rs2_q, rs2_dn, rdx_q, rdx_dn;

    // Flush beats stall; an invalid slot never carries control bits
    always_comb begin
        valid_d_n = valid_q;
        ctrl_dn   = ctrl_q;
        rd1_dn    = rd1_q;
        rd2_dn    = rd2_q;
        imm_dn    = imm_q;
        pc_dn     = pc_q;
        pc4_dn    = pc4_q;
        rs1_dn    = rs1_q;
        rs2_dn    = rs2_q;
        rdx_dn    = rdx_q;
        if (flush_e) begin
            valid_d_n = 1'b0;
            ctrl_dn   = '0;
            rd1_dn    = '0;
            rd2_dn    = '0;
            imm_dn    = '0;
            pc_dn     = '0;
            pc4_dn    = '0;
            rs1_dn    = '0;
            rs2_dn    = '0;
            rdx_dn    = '0;
        end else if (!stall_d) begin
            valid_d_n = valid_d;
            ctrl_dn   = valid_d ? ctrl_d : '0;
            rd1_dn    = rd1_rf;
            rd2_dn    = rd2_rf;
            imm_dn    = imm_d;
            pc_dn     = pc_d;
            pc4_dn    = pcplus4_d;
            rs1_dn    = rs1_a;
            rs2_dn    = rs2_a;
            rdx_dn    = rd_a;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rdx_q   <= '0;
        end else begin
            valid_q <= valid_d_n;
            ctrl_q  <= ctrl_dn;
            rd1_q   <= rd1_dn;
            rd2_q   <= rd2_dn;
            imm_q   <= imm_dn;
            pc_q    <= pc_dn;
            pc4_q   <= pc4_dn;
            rs1_q   <= rs1_dn;
            rs2_q   <= rs2_dn;
            rdx_q   <= rdx_dn;
        end
    end

    assign valid_e   = valid_q;
    assign ctrl_e    = ctrl_q;
    assign rd1_e     = rd1_q;
    assign rd2_e     = rd2_q;
    assign imm_e     = imm_q;
    assign pc_e      = pc_q;
    assign pcplus4_e = pc4_q;
    assign rs1_e     = rs1_q;
    assign rs2_e     = rs2_q;
    assign rd_e      = rdx_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Scoreboard bench for decode_stage_p (NREG=16): directed vectors, queued expectations.
module tb_decode_stage_p;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_d = '0;
    logic        valid_d = 1'b0;
    logic [8:0]  ctrl_d = '0;
    logic [31:0] imm_d = '0, pc_d = '0, pcplus4_d = '0;
    logic        stall_d = 1'b0, flush_e = 1'b0, regwrite_w = 1'b0;
    logic [4:0]  rd_w = '0;
    logic [31:0] result_w = '0;
    logic        valid_e;
    logic [8:0]  ctrl_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pcplus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    decode_stage_p #(.XLEN(32), .NREG(16), .CTRL_W(9)) dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .ctrl_d(ctrl_d),
        .imm_d(imm_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .stall_d(stall_d),
        .flush_e(flush_e), .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
        .valid_e(valid_e), .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
        .pc_e(pc_e), .pcplus4_e(pcplus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [8:0]  c;
        logic [31:0] r1, r2, im, p, p4;
        logic [4:0]  s1, s2, d;
    } exp_t;

`ifdef DECODE_STAGE_BYPASS_EN
    localparam logic [31:0] X7_SAME_CYCLE = 32'h0000_00AA;
`else
    localparam logic [31:0] X7_SAME_CYCLE = 32'h0000_0011;
`endif

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic exp_t mk(input logic v, input logic [8:0] c, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] im, input logic [31:0] p,
                                input logic [31:0] p4, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] d);
        exp_t e;
        e.v = v; e.c = c; e.r1 = r1; e.r2 = r2; e.im = im; e.p = p; e.p4 = p4;
        e.s1 = s1; e.s2 = s2; e.d = d;
        return e;
    endfunction

    function automatic exp_t actual();
        return mk(valid_e, ctrl_e, rd1_e, rd2_e, imm_e, pc_e, pcplus4_e, rs1_e, rs2_e, rd_e);
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = actual();
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got v=%0b c=%h r1=%h r2=%h im=%h pc=%h pc4=%h rs1=%0d rs2=%0d rd=%0d, want v=%0b c=%h r1=%h r2=%h im=%h pc=%h pc4=%h rs1=%0d rs2=%0d rd=%0d",
                      name, a.v, a.c, a.r1, a.r2, a.im, a.p, a.p4, a.s1, a.s2, a.d,
                      e.v, e.c, e.r1, e.r2, e.im, e.p, e.p4, e.s1, e.s2, e.d);
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                         input logic v, input logic [8:0] c, input logic [31:0] im,
                         input logic [31:0] p, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic st, input logic fl, input exp_t e);
        @(negedge clk);
        instr_d    = {7'd0, a2, a1, 3'd0, ad, 7'h33};
        valid_d    = v;
        ctrl_d     = c;
        imm_d      = im;
        pc_d       = p;
        pcplus4_d  = p + 32'd4;
        regwrite_w = we;
        rd_w       = wr;
        result_w   = wd;
        stall_d    = st;
        flush_e    = fl;
        exp_q.push_back(e);
    endtask

    // Monitor: one queued expectation per clock, sampled after the edge
    initial begin
        int idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check($sformatf("ex_slot%0d", idx), exp_q.pop_front());
                idx++;
            end
        end
    end

    initial begin
        exp_t e7, zero;
        zero = mk(1'b0, 9'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        check("reset_state", zero);
        rst = 1'b1;

        // invalid slot with nonzero ctrl_d; write x5
        drive(5'd0, 5'd0, 5'd0, 1'b0, 9'h1FF, 32'h55, 32'h100, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0,
              mk(1'b0, 9'h0, 32'h0, 32'h0, 32'h55, 32'h100, 32'h104, 5'd0, 5'd0, 5'd0));
        drive(5'd5, 5'd0, 5'd3, 1'b1, 9'h0A5, 32'h1, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
              mk(1'b1, 9'h0A5, 32'h1234, 32'h0, 32'h1, 32'h200, 32'h204, 5'd5, 5'd0, 5'd3));
        drive(5'd0, 5'd0, 5'd0, 1'b1, 9'h003, 32'h0, 32'h300, 1'b1, 5'd7, 32'h11, 1'b0, 1'b0,
              mk(1'b1, 9'h003, 32'h0, 32'h0, 32'h0, 32'h300, 32'h304, 5'd0, 5'd0, 5'd0));
        // write to x0 must be ignored, even when read in the same cycle
        drive(5'd0, 5'd5, 5'd0, 1'b1, 9'h001, 32'h0, 32'h304, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0,
              mk(1'b1, 9'h001, 32'h0, 32'h1234, 32'h0, 32'h304, 32'h308, 5'd0, 5'd5, 5'd0));
        // rd_w/rs1 = 20 is beyond NREG=16
        drive(5'd20, 5'd0, 5'd20, 1'b1, 9'h002, 32'h0, 32'h308, 1'b1, 5'd20, 32'hDEAD, 1'b0, 1'b0,
              mk(1'b1, 9'h002, 32'h0, 32'h0, 32'h0, 32'h308, 32'h30C, 5'd20, 5'd0, 5'd20));
        drive(5'd0, 5'd4, 5'd0, 1'b1, 9'h004, 32'h0, 32'h30C, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
              mk(1'b1, 9'h004, 32'h0, 32'h0, 32'h0, 32'h30C, 32'h310, 5'd0, 5'd4, 5'd0));
        // same-cycle write and read of x7
        e7 = mk(1'b1, 9'h1FF, 32'h1234, X7_SAME_CYCLE, 32'h7FF, 32'h400, 32'h404, 5'd5, 5'd7, 5'd9);
        drive(5'd5, 5'd7, 5'd9, 1'b1, 9'h1FF, 32'h7FF, 32'h400, 1'b1, 5'd7, 32'hAA, 1'b0, 1'b0, e7);
        // three stall cycles; x5 is rewritten during the first one
        drive(5'd5, 5'd1, 5'd2, 1'b1, 9'h00F, 32'h1, 32'h800, 1'b1, 5'd5, 32'h9999, 1'b1, 1'b0, e7);
        drive(5'd2, 5'd3, 5'd4, 1'b0, 9'h0F0, 32'h2, 32'h900, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, e7);
        drive(5'd6, 5'd8, 5'd10, 1'b1, 9'h111, 32'h3, 32'hA00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, e7);
        drive(5'd5, 5'd7, 5'd1, 1'b1, 9'h002, 32'h0, 32'h500, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
              mk(1'b1, 9'h002, 32'h9999, 32'hAA, 32'h0, 32'h500, 32'h504, 5'd5, 5'd7, 5'd1));
        // flush wins over stall
        drive(5'd5, 5'd7, 5'd1, 1'b1, 9'h1FF, 32'h3, 32'h600, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, zero);
        drive(5'd5, 5'd0, 5'd2, 1'b1, 9'h010, 32'h9, 32'h700, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
              mk(1'b1, 9'h010, 32'h9999, 32'h0, 32'h9, 32'h700, 32'h704, 5'd5, 5'd0, 5'd2));

        // asynchronous reset between edges while the slot is valid
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("async_reset_clear", zero);
        @(negedge clk);
        rst = 1'b1;
        drive(5'd5, 5'd0, 5'd0, 1'b1, 9'h020, 32'h0, 32'h800, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
              mk(1'b1, 9'h020, 32'h0, 32'h0, 32'h0, 32'h800, 32'h804, 5'd5, 5'd0, 5'd0));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
